// File: rtl/ucdp_latch_wrctrl.sv
// Write controller for a latch array: data setup, one-cycle one-hot load, optional data hold.
// Define UCDP_LATCH_WRCTRL_HOLD_EN to keep the HOLD cycle after each load pulse.
module ucdp_latch_wrctrl #(
  parameter  int width_p     = 1,
  parameter  int depth_p     = 4,
  localparam int addrwidth_p = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [addrwidth_p-1:0] req_addr_i,
  input  logic [width_p-1:0]     req_data_i,
  output logic [width_p-1:0]     d_o,
  output logic [depth_p-1:0]     ld_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam logic [31:0] depth_c = 32'(depth_p);

`ifdef UCDP_LATCH_WRCTRL_HOLD_EN
  typedef enum logic [1:0] {IDLE, SETUP, LOAD, HOLD} state_e;
`else
  typedef enum logic [1:0] {IDLE, SETUP, LOAD} state_e;
`endif

  state_e                 state_q, state_d;
  logic [addrwidth_p-1:0] addr_q, addr_d;
  logic [width_p-1:0]     d_q, d_d;
  logic [depth_p-1:0]     ld_q, ld_d;
  logic                   err_q, err_d;
  logic                   addr_ok;

  assign addr_ok = 32'(req_addr_i) < depth_c;

  // The load strobe is computed while in SETUP so it is registered high exactly during LOAD.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    d_d     = d_q;
    ld_d    = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (addr_ok) begin
            addr_d  = req_addr_i;
            d_d     = req_data_i;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        ld_d[addr_q] = 1'b1;
        state_d      = LOAD;
      end
`ifdef UCDP_LATCH_WRCTRL_HOLD_EN
      LOAD:    state_d = HOLD;
      HOLD:    state_d = IDLE;
`else
      LOAD:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      d_q     <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) && !main_rst_i;
  assign busy_o      = (state_q != IDLE);
  assign d_o         = d_q;
  assign ld_o        = ld_q;
  assign err_o       = err_q;

endmodule
